// File: rtl/seq_signed_muldiv.sv
// Sequential signed multiplier / divider: W-cycle shift-add or restoring
// shift-subtract core on operand magnitudes, with a final sign-fix cycle.
module seq_signed_muldiv #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic signed [2*W-1:0] product,
  output logic signed [W-1:0]   quotient,
  output logic signed [W-1:0]   remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic            op_q, neg_a, neg_b, dbz_q, ovf_q;
  logic [W-1:0]    mag_a, mag_b;
  logic [W-1:0]    hi, lo;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      sum, shifted;
  logic            ge;
  logic [2*W-1:0]  prod_mag;

  assign busy = (state != IDLE);

  // Magnitudes are W-bit unsigned, so -2^(W-1) maps cleanly to 2^(W-1).
  always_comb begin
    a_mag    = a[W-1] ? -a : a;
    b_mag    = b[W-1] ? -b : b;
    sum      = {1'b0, hi} + {1'b0, (lo[0] ? mag_b : '0)};
    shifted  = {hi, lo[W-1]};
    ge       = (shifted >= {1'b0, mag_b});
    prod_mag = {hi, lo};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      op_q  <= 1'b0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
      mag_a <= '0;
      mag_b <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt   <= CW'(W);
          op_q  <= op;
          neg_a <= a[W-1];
          neg_b <= b[W-1];
          dbz_q <= op && (b == '0);
          ovf_q <= op && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
          mag_a <= a_mag;
          mag_b <= b_mag;
          hi    <= '0;
          lo    <= a_mag;
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (!op_q) begin
            {hi, lo} <= {sum, lo[W-1:1]};
          end else begin
            hi <= ge ? W'(shifted - {1'b0, mag_b}) : shifted[W-1:0];
            lo <= {lo[W-2:0], ge};
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers only change in FIX, so they hold between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done        <= 1'b0;
      product     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (state == FIX) begin
        div_by_zero <= dbz_q;
        overflow    <= ovf_q;
        if (!op_q) begin
          product   <= (neg_a ^ neg_b) ? -prod_mag : prod_mag;
          quotient  <= '0;
          remainder <= '0;
        end else if (dbz_q) begin
          product   <= '0;
          quotient  <= '0;
          remainder <= neg_a ? -mag_a : mag_a;
        end else begin
          product   <= '0;
          quotient  <= (neg_a ^ neg_b) ? -lo : lo;
          remainder <= neg_a ? -hi : hi;
        end
      end
    end
  end

endmodule

// File: doc/seq_signed_muldiv.md
SEQ_SIGNED_MULDIV -- requirements
Module: seq_signed_muldiv

Interface
REQ-001 Parameter W, default 8: operand width in bits, legal range 4..32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  1  0 = multiply, 1 = divide; sampled with start.
REQ-006 a  input  W  signed two's-complement multiplicand / dividend.
REQ-007 b  input  W  signed two's-complement multiplier / divisor.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when results are valid.
REQ-010 product  output  2W  signed product, multiply only.
REQ-011 quotient  output  W  signed quotient, divide only.
REQ-012 remainder  output  W  signed remainder, divide only.
REQ-013 div_by_zero  output  1  high with done if a divide had b == 0.
REQ-014 overflow  output  1  high with done if a divide had a == -2^(W-1) and b == -1.

Function
REQ-015 FSM states: IDLE, CALC, FIX; IDLE is the reset state.
REQ-016 IDLE with start=1 at edge k: latch op, magnitudes of a and b, and result signs; load iteration counter with W; go to CALC.
REQ-017 CALC: one iteration per clock, shift-add for multiply, restoring shift-subtract for divide; counter decrements; after W edges (k+1..k+W) go to FIX.
REQ-018 FIX at edge k+W+1: apply sign correction, register all result outputs and flags, return to IDLE, assert done.
REQ-019 Latency fixed at W+1 clocks from accepting edge to done high, for both ops and all operand values, including b == 0.
REQ-020 done high exactly one cycle (cycle after edge k+W+1); busy high from edge k through edge k+W+1, low in the done cycle.
REQ-021 start while busy ignored, no effect on the running operation or its inputs.
REQ-022 start in the done cycle (state IDLE) accepted; back-to-back operations SHALL have no idle gap.
REQ-023 a and b may change after the accepting edge without affecting the result.
REQ-024 Multiply: product = a*b exact in 2W bits; quotient, remainder, div_by_zero, overflow SHALL be 0.
REQ-025 Divide: quotient truncates toward zero; remainder sign equals sign of a; a == quotient*b + remainder; product SHALL be 0.
REQ-026 Divide with b == 0: quotient = 0, remainder = a, div_by_zero = 1, overflow = 0.
REQ-027 Divide with a == -2^(W-1), b == -1: quotient = -2^(W-1) (wrapped), remainder = 0, overflow = 1.
REQ-028 All result outputs and flags SHALL hold their value from the done cycle until the next FIX update or reset.

Reset
REQ-029 rst high SHALL immediately force state IDLE and busy, done, product, quotient, remainder, div_by_zero, overflow, counter to 0.
REQ-030 rst asserted mid-operation aborts it; no done pulse for the aborted operation; first start after release SHALL begin a fresh operation.

Verification (W = 8)
REQ-031 op=0, a=-7, b=5 -> done 9 cycles after start edge, product=16'hFFDD (-35), other results 0.
REQ-032 op=0, a=-128, b=-128 -> product=16384; op=1, a=-7, b=2 -> quotient=-3, remainder=-1, flags 0.
REQ-033 op=1, a=5, b=0 -> quotient=0, remainder=5, div_by_zero=1, latency still 9.
REQ-034 op=1, a=-128, b=-1 -> quotient=-128, remainder=0, overflow=1.
REQ-035 start re-pulsed with new operands during busy -> ignored, first result unchanged; start in done cycle -> second result 9 cycles later.
REQ-036 rst pulsed at cycle 4 of a multiply -> all outputs 0 at once, no done pulse; next operation correct.
